// File: rtl/mmio_bus_pkg.sv
// Shared definitions for the MMIO bus: FSM state encoding, IO register offsets,
// status-word bit positions and the IO window decode helper.
package mmio_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IO_RESP  = 3'd1,
    ST_TX_WAIT  = 3'd2,
    ST_RAM_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Word offsets inside the IO window
  localparam logic [31:0] IO_OFF_DATA   = 32'd0;
  localparam logic [31:0] IO_OFF_STATUS = 32'd1;
  localparam logic [31:0] IO_OFF_TXRDY  = 32'd2;
  localparam logic [31:0] IO_OFF_CTRL   = 32'd3;

  localparam int unsigned STAT_OVF_BIT     = 32'd8;
  localparam int unsigned STAT_CNT_MSB     = 32'd7;
  localparam int unsigned CTRL_CLR_OVF_BIT = 32'd0;

  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] span);
    return (addr >= base) && (addr < (base + span));
  endfunction

endpackage

// File: rtl/mmio_bus_if.sv
// Core request, RAM request and UART signals of the MMIO bus, seen from the
// bus (slave) side and from the environment (master) side.
interface mmio_bus_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic              I_mem_exec;
  logic              I_mem_write;
  logic [ADDR_W-1:0] I_mem_addr;
  logic [DATA_W-1:0] I_mem_wdata;
  logic [DATA_W-1:0] O_mem_rdata;
  logic              O_mem_ready;
  logic              O_mem_data_ready;
  logic              O_ram_enable;
  logic              O_ram_write;
  logic [ADDR_W-1:0] O_ram_addr;
  logic [DATA_W-1:0] O_ram_wdata;
  logic [DATA_W-1:0] I_ram_rdata;
  logic              I_rx_valid;
  logic [7:0]        I_rx_data;
  logic              O_tx_exec;
  logic [7:0]        O_tx_data;
  logic              I_tx_ready;

  modport slave (
    input  I_mem_exec, I_mem_write, I_mem_addr, I_mem_wdata,
    output O_mem_rdata, O_mem_ready, O_mem_data_ready,
    output O_ram_enable, O_ram_write, O_ram_addr, O_ram_wdata,
    input  I_ram_rdata,
    input  I_rx_valid, I_rx_data,
    output O_tx_exec, O_tx_data,
    input  I_tx_ready
  );

  modport master (
    output I_mem_exec, I_mem_write, I_mem_addr, I_mem_wdata,
    input  O_mem_rdata, O_mem_ready, O_mem_data_ready,
    input  O_ram_enable, O_ram_write, O_ram_addr, O_ram_wdata,
    output I_ram_rdata,
    output I_rx_valid, I_rx_data,
    input  O_tx_exec, O_tx_data,
    output I_tx_ready
  );

endinterface

// File: rtl/mmio_rx_fifo.sv
// Receive byte buffer for the MMIO bus. A push into a full buffer is accepted
// only when a pop happens on the same edge; pop on empty is ignored.
module mmio_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rdata     = empty ? '0 : mem_q[rd_ptr_q];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Next storage, pointer and occupancy values
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_bus.sv
// MMIO bus: routes core requests to an IO window (UART TX/RX, status) or RAM.
// Define MMIO_BUS_RXFIFO_EN for an RX_DEPTH-entry RX buffer; otherwise one byte.
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned IO_BASE  = 32'h0000_0400,
  parameter int unsigned IO_SPAN  = 8,
  parameter int unsigned RAM_LAT  = 1,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic      I_clk,
  input  logic      I_reset_n,
  mmio_bus_if.slave bus
);

`ifdef MMIO_BUS_RXFIFO_EN
  localparam int unsigned FIFO_DEPTH = RX_DEPTH;
`else
  localparam int unsigned FIFO_DEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              data_ready_q, data_ready_d;
  logic              tx_exec_q, tx_exec_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ram_enable_q, ram_enable_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       addr_ext_s;
  logic [31:0]       io_off_s;
  logic              is_io_s;
  logic              accept_s;
  logic [DATA_W-1:0] io_rdata_s;
  logic              fifo_pop_s;
  logic [7:0]        fifo_rdata_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              ovf_set_s;
  logic              ovf_clr_s;

  assign addr_ext_s = 32'(bus.I_mem_addr);
  assign io_off_s   = addr_ext_s - IO_BASE;
  assign is_io_s    = addr_in_window(addr_ext_s, IO_BASE, IO_SPAN);
  assign accept_s   = (state_q == ST_IDLE) && bus.I_mem_exec;

  // RX side effects of an accepted IO access happen on the accept edge itself
  assign fifo_pop_s = accept_s && is_io_s && !bus.I_mem_write
                      && (io_off_s == IO_OFF_DATA) && !fifo_empty_s;
  assign ovf_clr_s  = accept_s && is_io_s && bus.I_mem_write
                      && (io_off_s == IO_OFF_CTRL) && bus.I_mem_wdata[CTRL_CLR_OVF_BIT];
  assign ovf_set_s  = bus.I_rx_valid && fifo_full_s && !fifo_pop_s;

  mmio_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (I_clk),
    .rst_n (I_reset_n),
    .push  (bus.I_rx_valid),
    .wdata (bus.I_rx_data),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // IO read data, sampled at accept and zero-extended
  always_comb begin
    io_rdata_s = '0;
    case (io_off_s)
      IO_OFF_DATA: begin
        io_rdata_s[7:0] = fifo_rdata_s;
      end
      IO_OFF_STATUS: begin
        io_rdata_s[STAT_OVF_BIT]     = ovf_q;
        io_rdata_s[STAT_CNT_MSB:0]   = 8'(fifo_count_s);
      end
      IO_OFF_TXRDY: begin
        io_rdata_s[0] = bus.I_tx_ready;
      end
      default: begin
        io_rdata_s = '0;
      end
    endcase
  end

  // Sticky overflow: a new overflow wins over a clear on the same edge
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Access FSM: next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    data_ready_d = 1'b0;
    tx_exec_d    = 1'b0;
    tx_data_d    = tx_data_q;
    ram_enable_d = ram_enable_q;
    ram_write_d  = ram_write_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    lat_cnt_d    = lat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_mem_exec) begin
          if (is_io_s) begin
            if (bus.I_mem_write) begin
              if (io_off_s == IO_OFF_DATA) begin
                tx_data_d = bus.I_mem_wdata[7:0];
                if (bus.I_tx_ready) begin
                  tx_exec_d    = 1'b1;
                  data_ready_d = 1'b1;
                  state_d      = ST_IO_RESP;
                end else begin
                  state_d = ST_TX_WAIT;
                end
              end else begin
                data_ready_d = 1'b1;
                state_d      = ST_IO_RESP;
              end
            end else begin
              rdata_d      = io_rdata_s;
              data_ready_d = 1'b1;
              state_d      = ST_IO_RESP;
            end
          end else begin
            ram_enable_d = 1'b1;
            ram_write_d  = bus.I_mem_write;
            ram_addr_d   = bus.I_mem_addr;
            ram_wdata_d  = bus.I_mem_wdata;
            lat_cnt_d    = '0;
            state_d      = ST_RAM_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IO_RESP: begin
        state_d = ST_IDLE;
      end
      ST_TX_WAIT: begin
        if (bus.I_tx_ready) begin
          tx_exec_d    = 1'b1;
          data_ready_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end
      ST_RAM_WAIT: begin
        if (lat_cnt_q == LAT_W'(RAM_LAT - 1)) begin
          if (!ram_write_q) begin
            rdata_d = bus.I_ram_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          ram_enable_d = 1'b0;
          ram_write_d  = 1'b0;
          data_ready_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q      <= ST_IDLE;
      rdata_q      <= '0;
      data_ready_q <= 1'b0;
      tx_exec_q    <= 1'b0;
      tx_data_q    <= 8'h00;
      ram_enable_q <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      lat_cnt_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      data_ready_q <= data_ready_d;
      tx_exec_q    <= tx_exec_d;
      tx_data_q    <= tx_data_d;
      ram_enable_q <= ram_enable_d;
      ram_write_q  <= ram_write_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.O_mem_ready      = (state_q == ST_IDLE);
  assign bus.O_mem_rdata      = rdata_q;
  assign bus.O_mem_data_ready = data_ready_q;
  assign bus.O_tx_exec        = tx_exec_q;
  assign bus.O_tx_data        = tx_data_q;
  assign bus.O_ram_enable     = ram_enable_q;
  assign bus.O_ram_write      = ram_write_q;
  assign bus.O_ram_addr       = ram_addr_q;
  assign bus.O_ram_wdata      = ram_wdata_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Randomized bench for mmio_bus against a transaction-level model (byte queue,
// overflow flag, last response data) built from the bus rules.
module tb_mmio_bus;

  localparam int unsigned RAM_LAT_P = 2;
  localparam int unsigned IO_BASE_P = 32'h0000_0400;
  localparam int unsigned IO_SPAN_P = 8;
`ifdef MMIO_BUS_RXFIFO_EN
  localparam int unsigned EFF_DEPTH = 4;
`else
  localparam int unsigned EFF_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmio_bus_if #(.DATA_W(16), .ADDR_W(16)) mb ();

  mmio_bus #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .IO_BASE  (IO_BASE_P),
    .IO_SPAN  (IO_SPAN_P),
    .RAM_LAT  (RAM_LAT_P),
    .RX_DEPTH (4)
  ) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (mb.slave)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  mq[$];
  bit          movf;
  logic [15:0] exp_rdata;
  bit          pop_pend, clr_pend, rx_rand;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Reference RX buffer: pop first, then push if room, else flag overflow
  task automatic model_edge(input bit push, input logic [7:0] b, input bit pop, input bit clr);
    bit set;
    set = 1'b0;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < int'(EFF_DEPTH)) mq.push_back(b);
      else set = 1'b1;
    end
    if (set) movf = 1'b1;
    else if (clr) movf = 1'b0;
  endtask

  task automatic tick();
    model_edge(mb.I_rx_valid, mb.I_rx_data, pop_pend, clr_pend);
    pop_pend = 1'b0;
    clr_pend = 1'b0;
    @(negedge clk);
    if (rx_rand) begin
      mb.I_rx_valid = ($urandom_range(0, 3) == 0);
      mb.I_rx_data  = 8'($urandom);
    end else begin
      mb.I_rx_valid = 1'b0;
    end
  endtask

  task automatic bus_access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                            input bit txr, input int tx_wait, input logic [15:0] ram_val);
    bit          io;
    logic [31:0] off;
    logic [15:0] exp_rd;
    io  = (32'(addr) >= IO_BASE_P) && (32'(addr) < IO_BASE_P + IO_SPAN_P);
    off = 32'(addr) - IO_BASE_P;
    chk_eq("ready_before_accept", mb.O_mem_ready, 1);
    mb.I_mem_exec  = 1'b1;
    mb.I_mem_write = wr;
    mb.I_mem_addr  = addr;
    mb.I_mem_wdata = wd;
    mb.I_tx_ready  = txr;
    if (io) begin
      exp_rd = 16'h0000;
      if (!wr && off == 32'd0 && mq.size() > 0) exp_rd = {8'h00, mq[0]};
      if (!wr && off == 32'd1) exp_rd = {7'h00, movf, 8'(mq.size())};
      if (!wr && off == 32'd2) exp_rd = {15'h0000, txr};
      pop_pend = !wr && (off == 32'd0);
      clr_pend = wr && (off == 32'd3) && wd[0];
      tick();
      mb.I_mem_exec = 1'b0;
      mb.I_mem_addr = 16'($urandom);
      mb.I_mem_wdata = 16'($urandom);
      if (wr && off == 32'd0 && !txr) begin
        for (int i = 0; i < tx_wait; i++) begin
          chk_eq("txwait_ready", mb.O_mem_ready, 0);
          chk_eq("txwait_dready", mb.O_mem_data_ready, 0);
          chk_eq("txwait_txexec", mb.O_tx_exec, 0);
          tick();
        end
        mb.I_tx_ready = 1'b1;
        tick();
      end
      if (!wr) exp_rdata = exp_rd;
      chk_eq("io_dready", mb.O_mem_data_ready, 1);
      chk_eq("io_busy", mb.O_mem_ready, 0);
      chk_eq("io_rdata", mb.O_mem_rdata, exp_rdata);
      chk_eq("io_txexec", mb.O_tx_exec, (wr && off == 32'd0) ? 1 : 0);
      if (wr && off == 32'd0) chk_eq("io_txdata", mb.O_tx_data, wd[7:0]);
      tick();
      chk_eq("io_dready_end", mb.O_mem_data_ready, 0);
      chk_eq("io_txexec_end", mb.O_tx_exec, 0);
      chk_eq("io_ready_end", mb.O_mem_ready, 1);
    end else begin
      tick();
      mb.I_mem_exec = 1'b0;
      mb.I_mem_addr = 16'($urandom);
      mb.I_mem_wdata = 16'($urandom);
      for (int k = 1; k <= int'(RAM_LAT_P); k++) begin
        chk_eq("ram_en", mb.O_ram_enable, 1);
        chk_eq("ram_write", mb.O_ram_write, wr);
        chk_eq("ram_addr", mb.O_ram_addr, addr);
        if (wr) chk_eq("ram_wdata", mb.O_ram_wdata, wd);
        chk_eq("ram_dready_early", mb.O_mem_data_ready, 0);
        chk_eq("ram_busy", mb.O_mem_ready, 0);
        mb.I_ram_rdata = (k == int'(RAM_LAT_P)) ? ram_val : 16'($urandom);
        tick();
      end
      if (!wr) exp_rdata = ram_val;
      chk_eq("ram_en_off", mb.O_ram_enable, 0);
      chk_eq("ram_dready", mb.O_mem_data_ready, 1);
      chk_eq("ram_rdata", mb.O_mem_rdata, exp_rdata);
      tick();
      chk_eq("ram_dready_end", mb.O_mem_data_ready, 0);
      chk_eq("ram_ready_end", mb.O_mem_ready, 1);
    end
  endtask

  task automatic push_bytes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      mb.I_rx_valid = 1'b1;
      mb.I_rx_data  = first + 8'(i);
      tick();
    end
  endtask

  task automatic model_reset();
    mq.delete();
    movf      = 1'b0;
    exp_rdata = 16'h0000;
    pop_pend  = 1'b0;
    clr_pend  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_ready"}, mb.O_mem_ready, 1);
    chk_eq({tag, "_dready"}, mb.O_mem_data_ready, 0);
    chk_eq({tag, "_txexec"}, mb.O_tx_exec, 0);
    chk_eq({tag, "_ramen"}, mb.O_ram_enable, 0);
    chk_eq({tag, "_ramaddr"}, mb.O_ram_addr, 0);
    chk_eq({tag, "_rdata"}, mb.O_mem_rdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mb.I_mem_exec = 1'b0; mb.I_mem_write = 1'b0; mb.I_mem_addr = 16'h0000;
    mb.I_mem_wdata = 16'h0000; mb.I_ram_rdata = 16'h0000; mb.I_rx_valid = 1'b0;
    mb.I_rx_data = 8'h00; mb.I_tx_ready = 1'b1;
    rx_rand = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk_eq("reset_txdata", mb.O_tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM read with the value presented on the last wait cycle
    bus_access(1'b0, 16'h0010, 16'h0000, 1'b1, 0, 16'hBEEF);
    bus_access(1'b1, 16'h0020, 16'h1234, 1'b1, 0, 16'h5555);
    bus_access(1'b0, 16'h03FF, 16'h0000, 1'b1, 0, 16'hA5A5);
    bus_access(1'b0, 16'h0408, 16'h0000, 1'b1, 0, 16'h0F0F);
    bus_access(1'b0, 16'h0407, 16'h0000, 1'b1, 0, 16'h0000);
    // TX write held off by a busy UART
    bus_access(1'b1, 16'h0400, 16'h0041, 1'b0, 5, 16'h0000);
    bus_access(1'b1, 16'h0400, 16'h0042, 1'b1, 0, 16'h0000);
    bus_access(1'b0, 16'h0402, 16'h0000, 1'b0, 0, 16'h0000);
    bus_access(1'b0, 16'h0402, 16'h0000, 1'b1, 0, 16'h0000);

    // Overflowing the RX buffer, then draining it
    push_bytes(5, 8'h01);
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);
    for (int i = 0; i < int'(EFF_DEPTH) + 1; i++)
      bus_access(1'b0, 16'h0400, 16'h0000, 1'b1, 0, 16'h0000);
    bus_access(1'b1, 16'h0403, 16'h0001, 1'b1, 0, 16'h0000);
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);

    // Push and pop on the same edge while full
    push_bytes(int'(EFF_DEPTH), 8'h10);
    mb.I_rx_valid = 1'b1; mb.I_rx_data = 8'hAA;
    bus_access(1'b0, 16'h0400, 16'h0000, 1'b1, 0, 16'h0000);
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);

    // Overflow set and clear on the same edge
    mb.I_rx_valid = 1'b1; mb.I_rx_data = 8'hBB;
    bus_access(1'b1, 16'h0403, 16'h0001, 1'b1, 0, 16'h0000);
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);
    bus_access(1'b1, 16'h0403, 16'h0001, 1'b1, 0, 16'h0000);
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);

    // Random traffic with background RX bytes
    rx_rand = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [15:0] a;
      bit          w;
      w = 1'($urandom);
      if ($urandom_range(0, 1) == 0) a = 16'(IO_BASE_P + $urandom_range(0, 7));
      else a = 16'($urandom);
      bus_access(w, a, 16'($urandom), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), 16'($urandom));
    end
    rx_rand = 1'b0;
    tick();

    // Reset during a TX wait: no late pulse after release
    push_bytes(1, 8'h77);
    mb.I_tx_ready = 1'b0; mb.I_mem_exec = 1'b1; mb.I_mem_write = 1'b1;
    mb.I_mem_addr = 16'h0400; mb.I_mem_wdata = 16'h0055;
    tick();
    mb.I_mem_exec = 1'b0;
    tick();
    chk_eq("txabort_busy", mb.O_mem_ready, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("txabort");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mb.I_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq("txabort_post_txexec", mb.O_tx_exec, 0);
      chk_eq("txabort_post_dready", mb.O_mem_data_ready, 0);
    end

    // Reset during a RAM wait
    push_bytes(1, 8'h66);
    bus_access(1'b0, 16'h0030, 16'h0000, 1'b1, 0, 16'h1357);
    mb.I_mem_exec = 1'b1; mb.I_mem_write = 1'b0; mb.I_mem_addr = 16'h0010;
    tick();
    mb.I_mem_exec = 1'b0;
    chk_eq("ramabort_en", mb.O_ram_enable, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("ramabort");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("ramabort_post_dready", mb.O_mem_data_ready, 0);
      chk_eq("ramabort_post_en", mb.O_ram_enable, 0);
    end
    bus_access(1'b0, 16'h0401, 16'h0000, 1'b1, 0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 16, bus data width; ADDR_W, 16, bus address width; IO_BASE, 16'h0400, first IO address; IO_SPAN, 8, IO window size in words; RAM_LAT, 1, RAM wait cycles (>=1); RX_DEPTH, 4, RX FIFO depth (power of 2).
REQ-002 SHALL have ports (name direction width meaning), with one clock; reset is asynchronous and active-low:
- I_clk in 1 clock
- I_reset_n in 1 async active-low reset
- I_mem_exec in 1 core request
- I_mem_write in 1 request is write
- I_mem_addr in ADDR_W request address
- I_mem_wdata in DATA_W write data
- O_mem_rdata out DATA_W read data
- O_mem_ready out 1 bus can accept
- O_mem_data_ready out 1 response pulse
- O_ram_enable out 1, O_ram_write out 1, O_ram_addr out ADDR_W, O_ram_wdata out DATA_W: RAM request
- I_ram_rdata in DATA_W RAM read data
- I_rx_valid in 1 UART byte strobe; I_rx_data in 8 UART byte
- O_tx_exec out 1 UART send pulse; O_tx_data out 8 UART byte; I_tx_ready in 1 UART idle

Function
REQ-003 SHALL accept a request on a clock edge where O_mem_ready=1 and I_mem_exec=1; O_mem_ready=1 only in IDLE.
REQ-004 SHALL decode IO when IO_BASE <= addr < IO_BASE+IO_SPAN, else RAM.
REQ-005 SHALL implement FSM IDLE, IO_RESP, TX_WAIT, RAM_WAIT, RESP; every non-IDLE state returns to IDLE.
REQ-006 IO offsets SHALL be: 0 write=TX byte (low 8 bits), read=pop RX byte; 1 read={overflow bit 8, count bits 7:0}; 2 read=I_tx_ready; 3 write bit0=1 clears overflow; others read 0, writes ignored.
REQ-007 IO access SHALL pulse O_mem_data_ready exactly one cycle, one cycle after accept; reads zero-extended.
REQ-008 TX write with I_tx_ready=1 SHALL pulse O_tx_exec one cycle after accept; with I_tx_ready=0 SHALL hold in TX_WAIT until I_tx_ready=1, then pulse O_tx_exec and O_mem_data_ready together.
REQ-009 RAM access SHALL register address/data/write at accept, hold O_ram_enable high RAM_LAT cycles, capture I_ram_rdata on the last, pulse O_mem_data_ready next cycle (latency RAM_LAT+1).
REQ-010 O_mem_rdata SHALL hold its value until the next response; writes respond with unchanged O_mem_rdata.
REQ-011 RX FIFO SHALL push on I_rx_valid; push when full SHALL drop byte and set sticky overflow.
REQ-012 Simultaneous push and pop SHALL both succeed, including when full (no overflow); pop when empty SHALL return 8'h00, count unchanged.
REQ-013 Overflow set and clear in same cycle SHALL leave overflow set.

Reset
REQ-014 I_reset_n low SHALL asynchronously force IDLE, O_mem_ready=1, all other outputs 0, FIFO empty, overflow 0.
REQ-015 Reset mid-access SHALL abort it with no O_tx_exec or O_mem_data_ready pulse after release.

Configuration
REQ-016 With MMIO_BUS_RXFIFO_EN defined, RX buffer SHALL be RX_DEPTH entries; undefined, SHALL be a single holding register (count max 1), all other behaviour identical.

Structure
REQ-017 Package mmio_bus_pkg SHALL hold FSM state encoding, IO offsets, status bit positions.
REQ-018 RX buffer SHALL be sub-module mmio_rx_fifo (params WIDTH=8, DEPTH; push/pop/full/empty/count).

Verification
REQ-019 Read 16'h0010 with RAM_LAT=2, RAM returns 16'hBEEF -> O_ram_enable 2 cycles, data_ready 3 cycles after accept, rdata 16'hBEEF.
REQ-020 Write 16'h0400 data 16'h0041, I_tx_ready=0 for 5 cycles -> O_mem_ready low, O_tx_exec pulses once with 8'h41 after I_tx_ready rises.
REQ-021 Push 5 bytes 8'h01..8'h05, depth 4 -> read 16'h0401 = 16'h0104; pops return 01..04 then 00.
REQ-022 Full FIFO, push and pop same cycle -> no overflow, count stays 4.
REQ-023 Write 16'h0403 data 1 -> overflow cleared, status 16'h0000 when empty.
REQ-024 Assert I_reset_n=0 during RAM_WAIT -> outputs reset immediately, no data_ready after release.
